// File: rtl/name_pkg.sv
// Shared definitions for the name-letter stream: sequence length, ASCII
// constants, and the state encodings of both the transmitter and detector.
package name_pkg;

  localparam int NAME_LEN   = 9;
  localparam int NAME_IDX_W = 4;

  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_U = 8'h55;
  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_E = 8'h45;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP,
    TX_FINISH
  } tx_state_e;

  // Detector progress through "RITUSHREE"; one state per matched prefix length.
  typedef enum logic [3:0] {
    DET_IDLE,
    DET_R1,
    DET_I,
    DET_T,
    DET_U,
    DET_S,
    DET_H,
    DET_R2,
    DET_E1,
    DET_E2
  } det_state_e;

endpackage

// File: rtl/name_char_rom.sv
// Combinational character-index to ASCII lookup for "RITUSHREE".
module name_char_rom
  import name_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic [NAME_IDX_W-1:0] idx,
  output logic [7:0]            ch
);

  always_comb begin
    case (idx)
      4'd0:    ch = CH_R;
      4'd1:    ch = CH_I;
      4'd2:    ch = CH_T;
      4'd3:    ch = CH_U;
      4'd4:    ch = CH_S;
      4'd5:    ch = CH_H;
      4'd6:    ch = CH_R;
      4'd7:    ch = CH_E;
      4'd8:    ch = CH_E;
      default: ch = FILL_CHAR;
    endcase
  end

endmodule

// File: rtl/name_sequence_tx.sv
// Transmitter for the name-letter stream: sends "RITUSHREE" rep_count times
// with a fixed idle gap between repetitions, honouring valid/ready backpressure.
module name_sequence_tx
  import name_pkg::*;
#(
  parameter int         CNT_W      = 4,
  parameter int         GAP_CYCLES = 2,
  parameter logic [7:0] FILL_CHAR  = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      rep_count,
  input  logic                  abort,
  input  logic                  ready,
  output logic [7:0]            letter,
  output logic                  valid,
  output logic                  busy,
  output logic [NAME_IDX_W-1:0] char_idx,
  output logic                  done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [NAME_IDX_W-1:0] LAST_IDX = NAME_IDX_W'(NAME_LEN - 1);

  tx_state_e             state_q, state_d;
  logic [NAME_IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      rep_q, rep_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [7:0]            letter_q, letter_d;
  logic [7:0]            rom_ch;

  name_char_rom #(.FILL_CHAR(FILL_CHAR)) u_rom (
    .idx (idx_d),
    .ch  (rom_ch)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        if (start && !abort) begin
          if (rep_count != '0) begin
            state_d = TX_SEND;
            rep_d   = rep_count;
            idx_d   = '0;
            valid_d = 1'b1;
          end else begin
            state_d = TX_FINISH;
            done_d  = 1'b1;
          end
        end
      end
      TX_SEND: begin
        valid_d = 1'b1;
        if (valid_q && ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + NAME_IDX_W'(1);
          end else begin
            rep_d = rep_q - CNT_W'(1);
            idx_d = '0;
            if (rep_d == '0) begin
              state_d = TX_FINISH;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_d = TX_GAP;
              valid_d = 1'b0;
              gap_d   = GAP_W'(GAP_CYCLES - 1);
            end
          end
        end
      end
      TX_GAP: begin
        if (gap_q == '0) begin
          state_d = TX_SEND;
          idx_d   = '0;
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      TX_FINISH: begin
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase

    // Abort overrides whatever the state logic decided, including a final beat.
    if (abort && state_q != TX_IDLE) begin
      state_d = TX_IDLE;
      idx_d   = '0;
      rep_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    busy_d   = (state_d != TX_IDLE);
    letter_d = valid_d ? rom_ch : FILL_CHAR;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      idx_q    <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      letter_q <= FILL_CHAR;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      letter_q <= letter_d;
    end
  end

  assign letter   = letter_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign char_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_name_sequence_tx.sv
// Self-checking bench for name_sequence_tx: scoreboarded beats, table-driven
// transactions and hand-written backpressure/abort/reset sequences.
module tb_name_sequence_tx;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] rep_count;
  logic       abort;
  logic       ready;
  logic [7:0] letter;
  logic       valid;
  logic       busy;
  logic [3:0] char_idx;
  logic       done;

  name_sequence_tx #(.CNT_W(4), .GAP_CYCLES(GAP), .FILL_CHAR(8'h20)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rep_count (rep_count),
    .abort     (abort),
    .ready     (ready),
    .letter    (letter),
    .valid     (valid),
    .busy      (busy),
    .char_idx  (char_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] ch;
  } beat_t;

  typedef struct {
    logic [3:0] rep;
    int         poke_cyc;   // cycle at which a spurious start is issued, 0 = none
    int         exp_cyc;    // cycle (start cycle = 0) in which done is seen
  } txn_t;

  beat_t sb[$];
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    done_cnt = 0;
  string name_str = "RITUSHREE";

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", what, act, exp, $time);
    end
  endtask

  function automatic int done_cycle(input int n);
    return (n == 0) ? 1 : 1 + 9 * n + GAP * (n - 1);
  endfunction

  task automatic push_reps(input int n);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < 9; i++) begin
        beat_t b;
        b.idx = 4'(i);
        b.ch  = name_str[i];
        sb.push_back(b);
      end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (valid && ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {24'h0, letter}, 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_letter", {24'h0, letter}, {24'h0, e.ch});
          check("beat_idx", {28'h0, char_idx}, {28'h0, e.idx});
        end
      end else if (!valid) begin
        check("idle_fill", {24'h0, letter}, 32'h20);
      end
    end
  end

  // Pulses start, then counts cycles until done; optionally fires a start
  // (with a different rep_count) while busy, which must be ignored.
  task automatic run_txn(input logic [3:0] rep, input int poke_cyc, input int exp_cyc,
                         input int extra_stall);
    int cyc;
    int d0;
    d0 = done_cnt;
    push_reps(int'(rep));
    @(posedge clk); #1;
    start = 1'b1; rep_count = rep;
    @(posedge clk); #1;
    start = 1'b0; rep_count = 4'd7;
    cyc = 1;
    while (cyc < 400) begin
      if (poke_cyc != 0 && cyc == poke_cyc) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
      if (done) break;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("done_cycle", cyc, exp_cyc + extra_stall);
    check("busy_at_done", {31'h0, busy}, 32'h1);
    check("sb_drained", sb.size(), 0);
    @(negedge clk);
    check("busy_after", {31'h0, busy}, 32'h0);
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("done_pulses", done_cnt - d0, 1);
  endtask

  txn_t txns[5];

  initial begin
    int d0;
    txns[0] = '{rep: 4'd1,  poke_cyc: 0, exp_cyc: done_cycle(1)};
    txns[1] = '{rep: 4'd3,  poke_cyc: 0, exp_cyc: done_cycle(3)};
    txns[2] = '{rep: 4'd0,  poke_cyc: 0, exp_cyc: done_cycle(0)};
    txns[3] = '{rep: 4'd2,  poke_cyc: 5, exp_cyc: done_cycle(2)};
    txns[4] = '{rep: 4'd15, poke_cyc: 0, exp_cyc: done_cycle(15)};

    rst = 1'b1; start = 1'b0; rep_count = '0; abort = 1'b0; ready = 1'b1;
    #12;
    check("rst_letter", {24'h0, letter}, 32'h20);
    check("rst_valid", {31'h0, valid}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_idx", {28'h0, char_idx}, 0);
    check("rst_done", {31'h0, done}, 0);
    rst = 1'b0;

    for (int t = 0; t < 5; t++)
      run_txn(txns[t].rep, txns[t].poke_cyc, txns[t].exp_cyc, 0);

    // Backpressure: stall 4 cycles on 'U'.
    fork
      run_txn(4'd1, 0, done_cycle(1), 4);
      begin : stall
        int w = 0;
        do begin @(posedge clk); #1; w++; end while (!(valid && char_idx == 4'd3) && w < 50);
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("stall_letter", {24'h0, letter}, 32'h55);
          check("stall_valid", {31'h0, valid}, 1);
          @(posedge clk); #1;
        end
        ready = 1'b1;
      end
    join

    // Abort on 'H': no done, returns to IDLE immediately.
    d0 = done_cnt;
    push_reps(1);
    @(posedge clk); #1; start = 1'b1; rep_count = 4'd1;
    @(posedge clk); #1; start = 1'b0;
    for (int w = 0; w < 50 && !(valid && char_idx == 4'd5); w++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_valid", {31'h0, valid}, 0);
    check("abort_letter", {24'h0, letter}, 32'h20);
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_idx", {28'h0, char_idx}, 0);
    check("abort_beats_left", sb.size(), 3);
    sb.delete();
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    run_txn(4'd1, 0, done_cycle(1), 0);

    // abort and start together in IDLE: stays idle.
    d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; abort = 1'b1; rep_count = 4'd2;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    check("abort_start_busy", {31'h0, busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_start_valid", {31'h0, valid}, 0);
    check("abort_start_done", done_cnt - d0, 0);

    // Asynchronous reset mid-SEND, checked before any clock edge.
    push_reps(1);
    @(posedge clk); #1; start = 1'b1; rep_count = 4'd1;
    @(posedge clk); #1; start = 1'b0;
    for (int w = 0; w < 50 && !(valid && char_idx == 4'd4); w++) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1;
    check("arst_valid", {31'h0, valid}, 0);
    check("arst_busy", {31'h0, busy}, 0);
    check("arst_done", {31'h0, done}, 0);
    check("arst_idx", {28'h0, char_idx}, 0);
    check("arst_letter", {24'h0, letter}, 32'h20);
    sb.delete();
    #1 rst = 1'b0;
    run_txn(4'd1, 0, done_cycle(1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
